// File: rtl/connect4_turn_ctrl.sv
// connect4_turn_ctrl: turn and game-state sequencer for the Connect Four datapath.
// Turns button pulses into cursor moves and one-cycle drop commands, hands each
// drop to the win checker, alternates players and detects a draw on a full board.
//
// Handshake: buttons, start and check_done are single-cycle pulses, each acted on
// only in the state that owns it (buttons in SELECT, start in IDLE/GAME_OVER,
// check_done in CHECK) and otherwise dropped. drop_en, new_game and drop_reject
// are single-cycle pulses. check_req is a level held for the whole of CHECK.
//
// Optional feature: define TURN_TIMER_EN to enable the per-turn forfeit timer.
// The default build has no timer and timeout_flag is tied low.
// fsm_state exposes the state register for observation.
module connect4_turn_ctrl #(
    parameter int NUM_COLS     = 7,
    parameter int MAX_MOVES    = 42,
    parameter int START_COL    = 3,
    parameter int TURN_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    input  logic       column_full,
    input  logic       check_done,
    input  logic       win_found,
    output logic       drop_en,
    output logic [2:0] column_select,
    output logic [1:0] player,
    output logic       check_req,
    output logic       new_game,
    output logic       drop_reject,
    output logic [5:0] move_count,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       timeout_flag,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        DROP      = 3'd2,
        SETTLE    = 3'd3,
        CHECK     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [2:0] LAST_COL  = 3'(NUM_COLS - 1);
    localparam logic [2:0] HOME_COL  = 3'(START_COL);
    localparam logic [5:0] MAX_MV    = 6'(MAX_MOVES);
    localparam logic [1:0] PLAYER_1  = 2'b01;

    state_t     state_q, state_d;
    logic [2:0] col_d;
    logic [1:0] player_d;
    logic [5:0] count_d;
    logic [1:0] winner_d;
    logic       drop_en_d, new_game_d, reject_d;
    logic [1:0] other_player;

    // Player encoding is one-hot over two bits, so swapping the bits toggles it.
    assign other_player = {player[0], player[1]};
    assign check_req    = (state_q == CHECK);
    assign game_over    = (state_q == GAME_OVER);
    assign fsm_state    = state_q;

`ifdef TURN_TIMER_EN
    localparam int TIMER_W = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);

    logic [TIMER_W-1:0] timer_q;
    logic               timer_expired;
    logic               tflag_d;

    assign timer_expired = (timer_q == TIMER_LAST);

    // Turn timer: counts cycles while SELECT persists, zero at every SELECT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   timer_q <= '0;
        else if (state_q == SELECT && state_d == SELECT) timer_q <= timer_q + 1'b1;
        else                                          timer_q <= '0;
    end

    // Timeout flag register, cleared by reset and by each new game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_flag <= 1'b0;
        else        timeout_flag <= tflag_d;
    end
`else
    assign timeout_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and next-value decode for all registered outputs.
    always_comb begin
        state_d    = state_q;
        col_d      = column_select;
        player_d   = player;
        count_d    = move_count;
        winner_d   = winner;
        drop_en_d  = 1'b0;
        new_game_d = 1'b0;
        reject_d   = 1'b0;
`ifdef TURN_TIMER_EN
        tflag_d    = timeout_flag;
`endif
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d    = SELECT;
                    new_game_d = 1'b1;
                    player_d   = PLAYER_1;
                    count_d    = '0;
                    winner_d   = 2'b00;
                    col_d      = HOME_COL;
`ifdef TURN_TIMER_EN
                    tflag_d    = 1'b0;
`endif
                end
            end
            SELECT: begin
                // A drop request wins over cursor moves and freezes the cursor.
                if (btn_drop) begin
                    if (!column_full) begin
                        state_d   = DROP;
                        drop_en_d = 1'b1;
                        if (move_count != MAX_MV) count_d = move_count + 6'd1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (btn_left && !btn_right) begin
                    col_d = (column_select == 3'd0) ? LAST_COL : column_select - 3'd1;
                end else if (btn_right && !btn_left) begin
                    col_d = (column_select == LAST_COL) ? 3'd0 : column_select + 3'd1;
                end
`ifdef TURN_TIMER_EN
                // Expiry forfeits the turn unless a drop was accepted this cycle.
                if (timer_expired && state_d != DROP) begin
                    state_d  = GAME_OVER;
                    winner_d = other_player;
                    tflag_d  = 1'b1;
                end
`endif
            end
            DROP:   state_d = SETTLE;
            SETTLE: state_d = CHECK;
            CHECK: begin
                if (check_done) begin
                    if (win_found) begin
                        state_d  = GAME_OVER;
                        winner_d = player;
                    end else if (move_count == MAX_MV) begin
                        state_d  = GAME_OVER;
                        winner_d = 2'b00;
                    end else begin
                        state_d  = SELECT;
                        player_d = other_player;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            column_select <= HOME_COL;
            player        <= PLAYER_1;
            move_count    <= '0;
            winner        <= 2'b00;
            drop_en       <= 1'b0;
            new_game      <= 1'b0;
            drop_reject   <= 1'b0;
        end else begin
            column_select <= col_d;
            player        <= player_d;
            move_count    <= count_d;
            winner        <= winner_d;
            drop_en       <= drop_en_d;
            new_game      <= new_game_d;
            drop_reject   <= reject_d;
        end
    end

endmodule

// File: doc/connect4_turn_ctrl.md
# connect4_turn_ctrl

Game sequencer for the Connect Four datapath. It turns debounced button pulses into cursor moves and one-cycle drop commands for the 6x7 grid storage block, and alternates players. After each drop it hands off to the win checker, then counts moves to detect a draw. It sits between the input controller and the grid/win-check blocks and owns all turn and game-state sequencing.

## Interface
Parameters:
- NUM_COLS, 7, number of columns; cursor range 0..NUM_COLS-1
- MAX_MOVES, 42, board capacity; reaching it without a win is a draw
- START_COL, 3, cursor position after reset and after each new game
- TURN_TIMEOUT, 50_000_000, cycles allowed per turn (only with TURN_TIMER_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a new game from IDLE or GAME_OVER
- btn_left  in  1  one-cycle pulse; move cursor left
- btn_right  in  1  one-cycle pulse; move cursor right
- btn_drop  in  1  one-cycle pulse; request a drop at the cursor
- column_full  in  1  grid status for column_select (combinational from grid)
- check_done  in  1  one-cycle pulse from win checker; result valid
- win_found  in  1  sampled only with check_done
- drop_en  out  1  one-cycle drop command to grid
- column_select  out  3  cursor column to grid
- player  out  2  01 = Player 1, 10 = Player 2; never 00 or 11
- check_req  out  1  level; high throughout CHECK
- new_game  out  1  one-cycle pulse; upstream clears the grid
- drop_reject  out  1  one-cycle pulse; drop refused because column is full
- move_count  out  6  accepted drops this game
- game_over  out  1  high in GAME_OVER
- winner  out  2  00 = none/draw, 01/10 = winning player
- timeout_flag  out  1  high in GAME_OVER when the game ended by timeout

## Operation
- States: IDLE, SELECT, DROP, SETTLE, CHECK, GAME_OVER.
- Reset: state IDLE, column_select = START_COL, player = 01, move_count = 0, winner = 00. All pulse and level outputs are 0.
- IDLE/GAME_OVER + start:
  - Go to SELECT.
  - Pulse new_game.
  - Set player = 01, move_count = 0, winner = 00, timeout_flag = 0, column_select = START_COL.
- start in any other state is ignored.
- SELECT, cursor moves:
  - btn_left at 0 wraps to NUM_COLS-1.
  - btn_right at NUM_COLS-1 wraps to 0.
  - btn_left and btn_right together: no move.
- SELECT, btn_drop:
  - btn_drop has priority over left/right in the same cycle; the cursor does not change.
  - If column_full = 0: go to DROP.
  - If column_full = 1: pulse drop_reject and stay in SELECT.
- DROP: drop_en = 1 for exactly this cycle; move_count increments; go to SETTLE.
- SETTLE: one cycle for the grid write to become visible; go to CHECK.
- CHECK: check_req = 1. Wait for check_done, then:
  - win_found = 1: go to GAME_OVER, winner = player.
  - Else if move_count == MAX_MOVES: go to GAME_OVER, winner = 00.
  - Else: toggle player (01<->10), go to SELECT. The cursor is retained.
- Buttons are ignored outside SELECT. check_done is ignored outside CHECK.
- move_count saturates at MAX_MOVES.

## Timing
- btn_drop accepted in cycle N gives:
  - drop_en high in N+1
  - SETTLE in N+2
  - check_req high from N+3
- check_done in cycle M: next state and player/winner updates are visible in M+1.
- Minimum turn length is 4 cycles (check_done in the first CHECK cycle).
- All outputs are registered except check_req and game_over, which decode the state register.
- rst_n assertion in any state, including DROP mid-pulse, forces reset values immediately. drop_en never stays high after reset.

## Configuration
- TURN_TIMER_EN defined:
  - A timer clears on every entry to SELECT and counts cycles spent in SELECT.
  - When it reaches TURN_TIMEOUT-1 with no drop accepted that cycle, the current player forfeits: go to GAME_OVER, winner = other player, timeout_flag = 1.
  - An accepted drop in the expiry cycle takes priority over the timeout.
- TURN_TIMER_EN undefined: no timer logic, timeout_flag tied to 0. TURN_TIMEOUT is unused.

## Test plan
- Reset, then start: new_game pulses once; column_select = 3, player = 01, state SELECT.
- Cursor wrap: 4x btn_left from 3 gives column_select 2,1,0,6. btn_right at 6 gives 0. Simultaneous left+right: no change.
- Drop with column_full = 0: drop_en high exactly 1 cycle at N+1 and check_req from N+3. check_done with win_found = 0 gives player 10 and move_count = 1.
- Drop with column_full = 1: drop_reject pulses, no drop_en, state stays SELECT, player unchanged.
- Win: check_done with win_found = 1 during player 10's turn gives game_over = 1, winner = 10. Buttons are then ignored; start restarts with player 01.
- Draw: 42 accepted drops, each with win_found = 0, end in game_over = 1, winner = 00. With TURN_TIMER_EN and TURN_TIMEOUT = 16, idling in SELECT gives winner = other player and timeout_flag = 1.
